// File: rtl/cook_timer.sv
// rtl/cook_timer.sv - microwave mm:ss BCD cook-time entry and one-second countdown
// Optional done beep output enabled by defining COOK_TIMER_BEEP_EN.
module cook_timer #(
    parameter int TICK_DIV  = 100,
    parameter int BEEP_SECS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clearN,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        mag_on,
    output logic [15:0] time_bcd,
    output logic        timer_done,
`ifdef COOK_TIMER_BEEP_EN
    output logic        done_pulse,
    output logic        beep
`else
    output logic        done_pulse
`endif
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic [15:0]   time_next;
    logic          time_nz;
    logic          running;
    logic          tick;
    logic          key_ok;
    logic          reach_zero;

    // mm:ss decrement; seconds borrow to 5x, all other digits borrow to 9
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] d0, d1, d2, d3;
        d0 = t[3:0];
        d1 = t[7:4];
        d2 = t[11:8];
        d3 = t[15:12];
        if (d0 != 4'd0) begin
            d0 = d0 - 4'd1;
        end else begin
            d0 = 4'd9;
            if (d1 != 4'd0) begin
                d1 = d1 - 4'd1;
            end else begin
                d1 = 4'd5;
                if (d2 != 4'd0) begin
                    d2 = d2 - 4'd1;
                end else begin
                    d2 = 4'd9;
                    d3 = d3 - 4'd1;
                end
            end
        end
        return {d3, d2, d1, d0};
    endfunction

    always_comb begin
        time_nz    = |time_bcd;
        running    = mag_on && time_nz;
        tick       = running && (presc == PW'(TICK_DIV - 1));
        key_ok     = key_valid && !mag_on && clearN && (key_digit <= 4'd9);
        reach_zero = clearN && tick && (time_bcd == 16'h0001);

        time_next  = time_bcd;
        presc_next = presc;
        if (!clearN) begin
            time_next  = 16'h0000;
            presc_next = '0;
        end else if (tick) begin
            time_next  = bcd_dec(time_bcd);
            presc_next = '0;
        end else if (running) begin
            presc_next = presc + PW'(1);
        end else if (key_ok) begin
            time_next  = {time_bcd[11:0], key_digit};
            presc_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_bcd   <= 16'h0000;
            presc      <= '0;
            timer_done <= 1'b1;
            done_pulse <= 1'b0;
        end else begin
            time_bcd   <= time_next;
            presc      <= presc_next;
            timer_done <= (time_next == 16'h0000);
            done_pulse <= reach_zero;
        end
    end

`ifdef COOK_TIMER_BEEP_EN
    localparam int BEEP_LEN = BEEP_SECS * TICK_DIV;
    localparam int BW       = $clog2(BEEP_LEN + 1);

    logic [BW-1:0] beep_cnt;

    // beep_cnt holds the remaining high cycles after the current one
    always_ff @(posedge clk) begin
        if (rst) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (!clearN || key_ok) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (reach_zero) begin
            beep     <= 1'b1;
            beep_cnt <= BW'(BEEP_LEN - 1);
        end else if (beep_cnt != '0) begin
            beep_cnt <= beep_cnt - BW'(1);
        end else begin
            beep     <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cook_timer.sv
// tb/tb_cook_timer.sv - directed bench for cook_timer with a seconds-level reference model
module tb_cook_timer;

    localparam int TICK_DIV  = 4;
    localparam int BEEP_SECS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clearN = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic        mag_on = 1'b0;
    logic [15:0] time_bcd;
    logic        timer_done;
    logic        done_pulse;
`ifdef COOK_TIMER_BEEP_EN
    logic        beep;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    // reference state: minutes and seconds as plain integers (seconds may be 60-99)
    int mins = 0, secs = 0, phase = 0, beep_left = 0;
    logic [15:0] exp_time = 16'h0000;
    bit exp_timer_done = 1'b1;
    bit exp_done = 1'b0;

    cook_timer #(.TICK_DIV(TICK_DIV), .BEEP_SECS(BEEP_SECS)) dut (
        .clk(clk),
        .rst(rst),
        .clearN(clearN),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .mag_on(mag_on),
        .time_bcd(time_bcd),
        .timer_done(timer_done),
`ifdef COOK_TIMER_BEEP_EN
        .done_pulse(done_pulse),
        .beep(beep)
`else
        .done_pulse(done_pulse)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        bit accept;
        accept   = 1'b0;
        exp_done = 1'b0;
        if (rst || !clearN) begin
            mins = 0; secs = 0; phase = 0;
        end else if (mag_on && (mins + secs) != 0) begin
            if (phase == TICK_DIV - 1) begin
                phase = 0;
                if (secs > 0) secs = secs - 1;
                else begin mins = mins - 1; secs = 59; end
                exp_done = (mins == 0 && secs == 0);
            end else begin
                phase = phase + 1;
            end
        end else if (key_valid && !mag_on && key_digit <= 9) begin
            accept = 1'b1;
            mins  = (mins % 10) * 10 + secs / 10;
            secs  = (secs % 10) * 10 + int'(key_digit);
            phase = 0;
        end
        if (rst || !clearN || accept) beep_left = 0;
        else if (exp_done) beep_left = BEEP_SECS * TICK_DIV;
        else if (beep_left > 0) beep_left = beep_left - 1;
        exp_time = 16'((mins / 10) << 12 | (mins % 10) << 8 | (secs / 10) << 4 | (secs % 10));
        exp_timer_done = (mins == 0 && secs == 0);
    end

    always @(negedge clk) begin
        if (checking) begin
            check("time_bcd", int'(time_bcd), int'(exp_time));
            check("timer_done", int'(timer_done), int'(exp_timer_done));
            check("done_pulse", int'(done_pulse), int'(exp_done));
`ifdef COOK_TIMER_BEEP_EN
            check("beep", int'(beep), int'(beep_left > 0));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic load(input logic [15:0] v);
        mag_on = 1'b0;
        clearN = 1'b0;
        step(1);
        clearN = 1'b1;
        key(v[15:12]); key(v[11:8]); key(v[7:4]); key(v[3:0]);
    endtask

    initial begin
        step(1);
        rst = 1'b0;
        checking = 1'b1;
        check("reset time", int'(time_bcd), 16'h0000);
        check("reset done", int'(timer_done), 1);
        check("reset pulse", int'(done_pulse), 0);

        key(4'd1); key(4'd3); key(4'd0);
        check("keys 130", int'(time_bcd), 16'h0130);
        check("keys done", int'(timer_done), 0);
        key(4'hA);
        check("key A ignored", int'(time_bcd), 16'h0130);
        mag_on = 1'b1;
        key(4'd7);
        check("key while on", int'(time_bcd), 16'h0130);

        load(16'h0002);
        mag_on = 1'b1;
        step(3);
        check("0002 hold", int'(time_bcd), 16'h0002);
        step(1);
        check("0002 to 0001", int'(time_bcd), 16'h0001);
        step(4);
        check("0001 to 0000", int'(time_bcd), 16'h0000);
        check("done pulse", int'(done_pulse), 1);
        check("timer done", int'(timer_done), 1);
        step(1);
        check("pulse one cycle", int'(done_pulse), 0);
        step(8);
        check("stays zero", int'(time_bcd), 16'h0000);

        load(16'h0100); mag_on = 1'b1; step(4);
        check("0100 dec", int'(time_bcd), 16'h0059);
        load(16'h0090); mag_on = 1'b1; step(4);
        check("0090 dec", int'(time_bcd), 16'h0089);
        load(16'h1000); mag_on = 1'b1; step(4);
        check("1000 dec", int'(time_bcd), 16'h0959);

        load(16'h0005);
        mag_on = 1'b1; step(2);
        mag_on = 1'b0; step(10);
        check("paused", int'(time_bcd), 16'h0005);
        mag_on = 1'b1; step(1);
        check("resume +1", int'(time_bcd), 16'h0005);
        step(1);
        check("resume +2", int'(time_bcd), 16'h0004);

        load(16'h0007);
        mag_on = 1'b1; step(2);
        clearN = 1'b0; step(1);
        clearN = 1'b1; mag_on = 1'b0;
        check("clear time", int'(time_bcd), 16'h0000);
        check("clear done", int'(timer_done), 1);
        check("clear pulse", int'(done_pulse), 0);

        load(16'h0007);
        mag_on = 1'b1; step(2);
        rst = 1'b1; step(1);
        rst = 1'b0; mag_on = 1'b0;
        check("rst time", int'(time_bcd), 16'h0000);
        check("rst done", int'(timer_done), 1);
        check("rst pulse", int'(done_pulse), 0);

`ifdef COOK_TIMER_BEEP_EN
        load(16'h0001);
        mag_on = 1'b1; step(4);
        mag_on = 1'b0;
        check("beep start", int'(beep), 1);
        step(7);
        check("beep last", int'(beep), 1);
        step(1);
        check("beep end", int'(beep), 0);

        load(16'h0001);
        mag_on = 1'b1; step(4);
        mag_on = 1'b0; step(2);
        check("beep before key", int'(beep), 1);
        key(4'd5);
        check("beep key cut", int'(beep), 0);
`endif

        step(2);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- Microwave cook-time countdown: accepts keypad digits as a 4-digit BCD mm:ss value and counts down once per second while the magnetron is on.
- Sits directly upstream of the start/stop/clear S/R control logic and supplies its timer_done input.
- Also drives the BCD time value to the display block.

Parameters:
- TICK_DIV, 100: clk cycles per one-second tick; minimum 2.
- BEEP_SECS, 3: length of the done beep in seconds; used only with COOK_TIMER_BEEP_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- clearN  input  1  active-low clear: zero the time.
- key_valid  input  1  one-cycle strobe; key_digit is valid.
- key_digit  input  4  BCD digit 0-9 from the keypad.
- mag_on  input  1  magnetron on; countdown enable (S/R latch output).
- time_bcd  output  16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- timer_done  output  1  registered level: high while time_bcd == 16'h0000.
- done_pulse  output  1  one-cycle pulse when countdown reaches zero.

Behaviour:
- Reset (rst=1 at a clk edge): time_bcd=0, prescaler=0, timer_done=1, done_pulse=0, beep=0.
- Priority each cycle: rst > clearN low > tick decrement > key entry.
- Key entry:
  - Accepted only when key_valid=1, mag_on=0, clearN=1 and key_digit<=9; otherwise ignored.
  - On accept, time_bcd <= {time_bcd[11:0], key_digit}; the leftmost digit is dropped and prescaler <= 0.
  - Any digit 0-9 is allowed in any position, so max entry 99:99; sec_tens > 5 is legal (e.g. 0:90 = 90 s).
- Prescaler:
  - Increments each cycle while mag_on=1 and time != 0.
  - Holds its value while mag_on=0, so a pause keeps the partial second.
  - At TICK_DIV-1 it wraps to 0 and generates a tick.
- Tick decrement (BCD borrow chain):
  - sec_ones: 0 -> 9 with borrow, else -1.
  - sec_tens on borrow: 0 -> 5 with borrow, else -1.
  - min_ones on borrow: 0 -> 9 with borrow, else -1.
  - min_tens on borrow: -1.
  - Borrow out of min_tens is impossible because a tick never occurs at 0000.
- Time zero:
  - No tick is generated and the prescaler holds at 0.
  - timer_done is registered from the next-state value, so it rises in the same cycle time_bcd becomes 0000.
- done_pulse:
  - High for exactly one cycle when a tick takes time from 00:01 to 00:00.
  - Not asserted by rst, clearN or a zero entry.
- clearN low: time_bcd <= 0 and prescaler <= 0, even while mag_on=1.
  - The resulting timer_done=1 makes downstream logic reset the magnetron latch.
- mag_on dropping mid-second: no tick; time and prescaler are frozen.
- Key entry while mag_on=1 is discarded; it is not queued.
- Latency: key accept to time_bcd update is 1 cycle; tick to time_bcd update is 1 cycle.

Optional Feature:
- COOK_TIMER_BEEP_EN defined:
  - Adds output port beep (1 bit), reset 0.
  - beep goes high on done_pulse and stays high for BEEP_SECS*TICK_DIV cycles, counted by its own counter.
  - beep is cleared early by clearN low or an accepted key.
  - A new done_pulse during beep restarts the count.
- Undefined: no beep port and no beep counter; all other behaviour is identical.

Test Plan (TICK_DIV=4, BEEP_SECS=2):
- Reset then keys 1,3,0: time_bcd=16'h0130, timer_done=0 one cycle after the last key. Key 4'hA: no change. Key entry with mag_on=1: no change.
- Load 00:02, mag_on=1 continuously: 0001 after 4 cycles, 0000 after 8. done_pulse is high in the cycle time_bcd becomes 0000. timer_done=1 from that same cycle. No further ticks.
- Load 01:00, run 1 tick: time_bcd=16'h0059. Load 00:90, run 1 tick: 16'h0089. Load 10:00, 1 tick: 16'h0959.
- Pause: load 00:05, mag_on=1 for 2 cycles, 0 for 10, 1 again. First decrement to 0004 occurs exactly 2 further cycles later.
- clearN low while counting at 00:07: time_bcd=0, timer_done=1, done_pulse stays 0. rst mid-count behaves the same.
- With COOK_TIMER_BEEP_EN: count 00:01 to zero. beep is high for 8 cycles starting with done_pulse. Repeat, then accept a key during beep: beep drops the next cycle.
